maze_out_arb: RTL and testbench

- Packet-level round-robin arbiter for one MAZE node output port.
- Merges NUM_IN valid/ready input streams into one stream. The stream is carried as multi-flit packets delimited by a last flag.
- Its output feeds the output-port IRS buffer directly; ready_i comes from that buffer's ready_o.
- Holds its grant for the whole packet, so flits from different sources never interleave.

---
 rtl/maze_out_arb.sv | 123 ++++++++++++
 tb/tb_maze_out_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/maze_out_arb.sv
// Packet-level round-robin arbiter for one MAZE node output port.
// Merges NUM_IN valid/ready flit streams and keeps the grant until the tail flit is accepted.
module maze_out_arb #(
  parameter int NUM_IN = 4,
  parameter int PYLD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          valid_i,
  input  logic [NUM_IN-1:0]          last_i,
  input  logic [NUM_IN*PYLD_W-1:0]   payload_i,
  output logic [NUM_IN-1:0]          ready_o,
  output logic                       valid_o,
  output logic                       last_o,
  output logic [PYLD_W-1:0]          payload_o,
  input  logic                       ready_i,
  output logic [NUM_IN-1:0]          gnt_o,
  output logic                       busy_o
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_W:0]   NUM_IN_W = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] ptr_r;
  logic             en_r;

  logic [IDX_W-1:0] pick_s;
  logic             found_s;
  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] sel_s;
  logic             active_s;
  logic             valid_s;
  logic             last_s;
  logic             hs_s;
  logic [NUM_IN-1:0] gnt_s;
  logic [PYLD_W-1:0] pay_arr_s [NUM_IN];

  // Round-robin scan from ptr_r+1; walking downward leaves the nearest valid candidate as the winner.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = NUM_IN; i >= 1; i--) begin
      cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
      if (cand_s >= NUM_IN_W) begin
        cand_s = cand_s - NUM_IN_W;
      end else begin
        cand_s = cand_s;
      end
      if (valid_i[cand_s[IDX_W-1:0]]) begin
        pick_s  = cand_s[IDX_W-1:0];
        found_s = 1'b1;
      end else begin
        pick_s  = pick_s;
        found_s = found_s;
      end
    end
  end

  // Unpack the flat payload bus into per-input words.
  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      pay_arr_s[k] = payload_i[k*PYLD_W +: PYLD_W];
    end
  end

  // Zero-latency select path; everything is held low until en_r rises after reset.
  always_comb begin
    sel_s    = (state_r == LOCK) ? owner_r : pick_s;
    active_s = en_r & ((state_r == LOCK) | found_s);
    valid_s  = active_s & valid_i[sel_s];
    last_s   = active_s & last_i[sel_s];
    hs_s     = valid_s & ready_i;
    gnt_s    = '0;
    gnt_s[sel_s] = active_s;
  end

  assign valid_o   = valid_s;
  assign last_o    = last_s;
  assign payload_o = active_s ? pay_arr_s[sel_s] : '0;
  assign gnt_o     = gnt_s;
  assign ready_o   = gnt_s & {NUM_IN{ready_i}};
  assign busy_o    = en_r & (state_r == LOCK);

  // Grant FSM: an offered but unfinished packet freezes the choice in LOCK until its tail is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= LAST_IDX;
      en_r    <= 1'b0;
    end else begin
      en_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            if (hs_s && last_s) begin
              ptr_r <= pick_s;
            end else begin
              state_r <= LOCK;
              owner_r <= pick_s;
            end
          end
        end
        LOCK: begin
          if (hs_s && last_s) begin
            state_r <= IDLE;
            ptr_r   <= owner_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_out_arb.sv
// Bench for maze_out_arb: directed vector table, async-reset sequence, then
// randomized traffic checked against a packet-level reference model.
module tb_maze_out_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   valid_i = '0;
  logic [N-1:0]   last_i = '0;
  logic [N*W-1:0] payload_i = '0;
  logic [N-1:0]   ready_o;
  logic           valid_o;
  logic           last_o;
  logic [W-1:0]   payload_o;
  logic           ready_i = 1'b0;
  logic [N-1:0]   gnt_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  maze_out_arb #(.NUM_IN(N), .PYLD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .last_i(last_i),
    .payload_i(payload_i), .ready_o(ready_o), .valid_o(valid_o),
    .last_o(last_o), .payload_o(payload_o), .ready_i(ready_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 when idle), last winner, enable after reset.
  logic m_en;
  logic m_lock;
  int   m_owner;
  int   m_ptr;
  int   m_sel;

  function automatic int model_sel();
    int s;
    s = -1;
    if (m_en) begin
      if (m_lock) s = m_owner;
      else begin
        for (int i = N; i >= 1; i--) begin
          if (valid_i[(m_ptr + i) % N]) s = (m_ptr + i) % N;
        end
      end
    end
    return s;
  endfunction

  always_comb m_sel = model_sel();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 1'b0; m_lock <= 1'b0; m_owner <= 0; m_ptr <= N - 1;
    end else begin
      m_en <= 1'b1;
      if (m_sel >= 0 && valid_i[m_sel]) begin
        if (ready_i && last_i[m_sel]) begin
          m_lock <= 1'b0;
          m_ptr  <= m_sel;
        end else begin
          m_lock  <= 1'b1;
          m_owner <= m_sel;
        end
      end
    end
  end

  task automatic check_model();
    logic [N-1:0] eg;
    logic ev, el;
    eg = '0; ev = 1'b0; el = 1'b0;
    if (m_sel >= 0) begin
      eg[m_sel] = 1'b1;
      ev = valid_i[m_sel];
      el = last_i[m_sel];
    end
    chk("m_valid", 32'(valid_o), 32'(ev));
    chk("m_last", 32'(last_o), 32'(el));
    chk("m_gnt", 32'(gnt_o), 32'(eg));
    chk("m_ready", 32'(ready_o), 32'(eg & {N{ready_i}}));
    chk("m_busy", 32'(busy_o), 32'(m_en & m_lock));
    if (ev) chk("m_payload", payload_o, payload_i[m_sel*W +: W]);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         rdy;
    logic [N-1:0] gnt;
    logic         ev;
    logic         eb;
    logic         el;
    int           sel;
  } vec_t;

  vec_t tbl [20];

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
    valid_i = v;
    last_i  = l;
    ready_i = rdy;
    for (int k = 0; k < N; k++) payload_i[k*W +: W] = {8'(k + 1), 24'hC0FFEE};
  endtask

  logic [N-1:0] acc;
  logic [N-1:0] cur_v;
  logic [N-1:0] cur_l;
  logic [W-1:0] cur_p [N];

  initial begin
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, -1};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 3};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 0};
    tbl[6]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1};
    tbl[8]  = '{4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1};
    tbl[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2};
    tbl[10] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 3};
    tbl[11] = '{4'b0001, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, -1};
    tbl[12] = '{4'b0001, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, -1};
    tbl[13] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 3};
    tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 0};
    tbl[15] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 0};
    tbl[16] = '{4'b0101, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 0};
    tbl[17] = '{4'b0101, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 0};
    tbl[18] = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 0};
    tbl[19] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2};

    drive(4'b1111, 4'b1111, 1'b1);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      if (r != 0) @(negedge clk);
      if (r == 0) rst_n = 1'b1;
      drive(tbl[r].v, tbl[r].l, tbl[r].rdy);
      #1;
      chk($sformatf("tbl%0d_valid", r), 32'(valid_o), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_gnt", r), 32'(gnt_o), 32'(tbl[r].gnt));
      chk($sformatf("tbl%0d_busy", r), 32'(busy_o), 32'(tbl[r].eb));
      chk($sformatf("tbl%0d_last", r), 32'(last_o), 32'(tbl[r].el));
      chk($sformatf("tbl%0d_ready", r), 32'(ready_o), 32'(tbl[r].gnt & {N{tbl[r].rdy}}));
      if (tbl[r].sel >= 0)
        chk($sformatf("tbl%0d_payload", r), payload_o, {8'(tbl[r].sel + 1), 24'hC0FFEE});
    end

    // Async reset in the middle of a packet owned by input 2.
    @(negedge clk);
    drive(4'b0100, 4'b0000, 1'b1);
    #1;
    chk("lk_gnt0", 32'(gnt_o), 32'h4);
    chk("lk_busy0", 32'(busy_o), 32'd0);
    @(negedge clk);
    #1;
    chk("lk_gnt1", 32'(gnt_o), 32'h4);
    chk("lk_busy1", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_gnt", 32'(gnt_o), 32'd0);
    chk("ar_ready", 32'(ready_o), 32'd0);
    drive(4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_gnt", 32'(gnt_o), 32'h1);
    chk("rel_busy", 32'(busy_o), 32'd0);
    chk("rel_valid1", 32'(valid_o), 32'd1);

    // Random traffic; a flit is held until its acceptance is seen.
    acc   = '1;
    cur_v = '0;
    cur_l = '0;
    for (int k = 0; k < N; k++) cur_p[k] = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (acc[k] || !cur_v[k]) begin
          cur_v[k] = ($urandom_range(0, 99) < 55);
          cur_l[k] = cur_v[k] && ($urandom_range(0, 2) == 0);
          cur_p[k] = $urandom;
        end
        payload_i[k*W +: W] = cur_p[k];
      end
      valid_i = cur_v;
      last_i  = cur_l;
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      check_model();
      acc = valid_i & ready_o & {N{ready_i}};
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
